// File: rtl/dsi_long_pkt_builder_if.sv
// Byte-stream link between the DSI long-packet builder and the lane distributor.
// The master presents bytes with sop/eop framing; the slave answers with ready.
interface dsi_long_pkt_builder_if;
    logic [7:0] pkt_byte;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_sop;
    logic       pkt_eop;

    modport master (
        output pkt_byte,
        output pkt_valid,
        output pkt_sop,
        output pkt_eop,
        input  pkt_ready
    );

    modport slave (
        input  pkt_byte,
        input  pkt_valid,
        input  pkt_sop,
        input  pkt_eop,
        output pkt_ready
    );
endinterface

// File: rtl/dsi_long_pkt_builder.sv
// Wraps one captured line into a MIPI DSI long packet (header, payload, checksum).
// Define DSI_PKT_CRC_EN to compute the CRC-16 checksum; otherwise both checksum bytes are 8'h00.
module dsi_long_pkt_builder #(
    parameter int          FRAME_LENGTH = 8,
    parameter logic [5:0]  DATA_TYPE    = 6'h3E,
    parameter logic [1:0]  VC           = 2'd0
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic [FRAME_LENGTH*24-1:0] payload,
    input  logic [15:0]                WC,
    input  logic                       fifo_done,
    dsi_long_pkt_builder_if.master     pkt,
    output logic                       busy,
    output logic                       overflow,
    output logic                       wc_err
);
    localparam int          MAXB    = FRAME_LENGTH * 3;
    localparam int          IW      = $clog2(MAXB + 1);
    localparam logic [15:0] MAX_WC  = 16'(MAXB);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [IW-1:0] IDX_HDR_LAST = IW'(3);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_PAY = 2'd2, ST_CRC = 2'd3} state_t;

    state_t                     state_r;
    logic [IW-1:0]              idx_r;
    logic [FRAME_LENGTH*24-1:0] data_r;
    logic [15:0]                wc_r;
    logic [7:0]                 byte_r;
    logic                       valid_r, sop_r, eop_r, busy_r, overflow_r, wc_err_r;

    logic          accept_s, last_pay_s;
    logic [15:0]   eff_wc_s, chk_s, chk_next_s;
    logic [IW-1:0] idx_next_s;
    logic [7:0]    pay_next_s, hdr_next_s;

    function automatic logic [7:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = (^d[19:10])^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] wc);
        case (idx)
            2'd1:    return wc[7:0];
            2'd2:    return wc[15:8];
            2'd3:    return ecc_calc({wc, VC, DATA_TYPE});
            default: return {VC, DATA_TYPE};
        endcase
    endfunction

    assign accept_s   = valid_r & pkt.pkt_ready;
    assign eff_wc_s   = (WC > MAX_WC) ? MAX_WC : WC;
    assign idx_next_s = idx_r + IDX_ONE;
    assign last_pay_s = ({{(16-IW){1'b0}}, idx_r} == (wc_r - 16'd1));
    assign hdr_next_s = hdr_byte(idx_next_s[1:0], wc_r);

    // Select the captured payload byte that follows the one currently presented.
    always_comb begin
        pay_next_s = 8'h00;
        for (int k = 0; k < MAXB; k++) begin
            pay_next_s = (idx_next_s == k[IW-1:0]) ? data_r[k*8 +: 8] : pay_next_s;
        end
    end

`ifdef DSI_PKT_CRC_EN
    logic [15:0] crc_r;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    assign chk_next_s = crc16_byte(crc_r, byte_r);
    assign chk_s      = crc_r;

    // Running checksum over payload bytes as they are accepted downstream.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            crc_r <= 16'hFFFF;
        end else if (state_r == ST_IDLE && fifo_done) begin
            crc_r <= 16'hFFFF;
        end else if (state_r == ST_PAY && accept_s) begin
            crc_r <= chk_next_s;
        end else begin
            crc_r <= crc_r;
        end
    end
`else
    assign chk_next_s = 16'h0000;
    assign chk_s      = 16'h0000;
`endif

    // Packet sequencer: every output is loaded with the byte to present after each accept.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            data_r     <= '0;
            wc_r       <= 16'h0000;
            byte_r     <= 8'h00;
            valid_r    <= 1'b0;
            sop_r      <= 1'b0;
            eop_r      <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
            wc_err_r   <= 1'b0;
        end else begin
            if (fifo_done && state_r != ST_IDLE) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (fifo_done) begin
                        data_r  <= payload;
                        wc_r    <= eff_wc_s;
                        if (WC > MAX_WC) begin
                            wc_err_r <= 1'b1;
                        end
                        state_r <= ST_HDR;
                        idx_r   <= '0;
                        byte_r  <= {VC, DATA_TYPE};
                        valid_r <= 1'b1;
                        sop_r   <= 1'b1;
                        eop_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
                        sop_r <= 1'b0;
                        idx_r <= (idx_r == IDX_HDR_LAST) ? '0 : idx_next_s;
                        if (idx_r != IDX_HDR_LAST) begin
                            byte_r <= hdr_next_s;
                        end else if (wc_r != 16'h0000) begin
                            state_r <= ST_PAY;
                            byte_r  <= data_r[7:0];
                        end else begin
                            state_r <= ST_CRC;
                            byte_r  <= chk_s[7:0];
                        end
                    end
                end
                ST_PAY: begin
                    if (accept_s) begin
                        if (last_pay_s) begin
                            state_r <= ST_CRC;
                            idx_r   <= '0;
                            byte_r  <= chk_next_s[7:0];
                        end else begin
                            idx_r  <= idx_next_s;
                            byte_r <= pay_next_s;
                        end
                    end
                end
                ST_CRC: begin
                    if (accept_s) begin
                        if (idx_r == '0) begin
                            idx_r  <= IDX_ONE;
                            byte_r <= chk_s[15:8];
                            eop_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            idx_r   <= '0;
                            byte_r  <= 8'h00;
                            valid_r <= 1'b0;
                            eop_r   <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                    valid_r <= 1'b0;
                    sop_r   <= 1'b0;
                    eop_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pkt.pkt_byte  = byte_r;
    assign pkt.pkt_valid = valid_r;
    assign pkt.pkt_sop   = sop_r;
    assign pkt.pkt_eop   = eop_r;
    assign busy          = busy_r;
    assign overflow      = overflow_r;
    assign wc_err        = wc_err_r;
endmodule

// File: tb/tb_dsi_long_pkt_builder.sv
// Scoreboard bench for dsi_long_pkt_builder: a packet-level model queues expected bytes,
// a negedge monitor pops them on every accepted byte and checks hold-while-stalled.
`timescale 1ns/1ps
module tb_dsi_long_pkt_builder;
    localparam int FL   = 8;
    localparam int MAXB = FL * 3;
    localparam int PW   = FL * 24;
    localparam logic [23:0] ECC_MASK [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                             24'hB8E38E, 24'hDF03F0, 24'hEFFC00};

    typedef struct packed {
        logic [7:0] b;
        logic       sop;
        logic       eop;
    } exp_t;

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] payload = '0;
    logic [15:0]   wc = 16'h0000;
    logic          fifo_done = 1'b0;
    logic          busy, overflow, wc_err;

    exp_t       exp_q[$];
    logic [7:0] got_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         rand_ready = 1'b0;
    bit         hold_v = 1'b0;
    logic [9:0] hold_val = '0;

    dsi_long_pkt_builder_if pkt_if();

    dsi_long_pkt_builder #(.FRAME_LENGTH(FL), .DATA_TYPE(6'h3E), .VC(2'd0)) dut (
        .pclk(pclk), .rst(rst), .payload(payload), .WC(wc), .fifo_done(fifo_done),
        .pkt(pkt_if.master), .busy(busy), .overflow(overflow), .wc_err(wc_err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < 6; i++) e[i] = ^(d & ECC_MASK[i]);
        return e;
    endfunction

    function automatic logic [PW-1:0] rnd_payload();
        logic [PW-1:0] r;
        for (int k = 0; k < PW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference packet: header, clamped payload, bit-serial reflected CRC-16 (or zeros).
    task automatic push_pkt(input logic [15:0] w, input logic [PW-1:0] p);
        logic [15:0] eff;
        logic [15:0] crc;
        logic [15:0] chk;
        logic [7:0]  di;
        logic [7:0]  by;
        logic        fb;
        logic [7:0]  pb[$];
        eff = (w > 16'(MAXB)) ? 16'(MAXB) : w;
        di  = {2'd0, 6'h3E};
        pb  = {};
        pb.push_back(di);
        pb.push_back(eff[7:0]);
        pb.push_back(eff[15:8]);
        pb.push_back(ecc_model({eff, di}));
        crc = 16'hFFFF;
        for (int k = 0; k < int'(eff); k++) begin
            by = p[k*8 +: 8];
            pb.push_back(by);
            for (int j = 0; j < 8; j++) begin
                fb  = crc[0] ^ by[j];
                crc = crc >> 1;
                if (fb) crc = crc ^ 16'h8408;
            end
        end
`ifdef DSI_PKT_CRC_EN
        chk = crc;
`else
        chk = 16'h0000;
`endif
        pb.push_back(chk[7:0]);
        pb.push_back(chk[15:8]);
        foreach (pb[i]) exp_q.push_back('{b: pb[i], sop: (i == 0), eop: (i == pb.size() - 1)});
    endtask

    task automatic send(input logic [15:0] w, input logic [PW-1:0] p, input bit expect_start);
        payload   = p;
        wc        = w;
        fifo_done = 1'b1;
        if (expect_start) push_pkt(w, p);
        @(posedge pclk);
        #1;
        fifo_done = 1'b0;
        if (expect_start) begin
            check("first_valid", {31'd0, pkt_if.pkt_valid}, 32'd1);
            check("first_sop", {31'd0, pkt_if.pkt_sop}, 32'd1);
            check("busy_set", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge pclk);
            #1;
            n++;
        end
        check({name, "_done"}, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
        check({name, "_valid_low"}, {31'd0, pkt_if.pkt_valid}, 32'd0);
        @(posedge pclk);
        #1;
    endtask

    // Downstream ready: always-on or ~50% random depending on the current phase.
    initial begin
        pkt_if.pkt_ready = 1'b1;
        forever begin
            @(posedge pclk);
            #1;
            pkt_if.pkt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare every accepted byte with the scoreboard, check stalls hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_valid", {31'd0, pkt_if.pkt_valid}, 32'd1);
                    check("hold_data", {22'd0, pkt_if.pkt_byte, pkt_if.pkt_sop, pkt_if.pkt_eop},
                          {22'd0, hold_val});
                end
                if (pkt_if.pkt_valid && pkt_if.pkt_ready) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got %0h, expected no byte", pkt_if.pkt_byte);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {24'd0, pkt_if.pkt_byte}, {24'd0, e.b});
                        check("sop", {31'd0, pkt_if.pkt_sop}, {31'd0, e.sop});
                        check("eop", {31'd0, pkt_if.pkt_eop}, {31'd0, e.eop});
                    end
                    if (pkt_if.pkt_sop) got_q = {};
                    got_q.push_back(pkt_if.pkt_byte);
                end else if (pkt_if.pkt_valid) begin
                    hold_v   = 1'b1;
                    hold_val = {pkt_if.pkt_byte, pkt_if.pkt_sop, pkt_if.pkt_eop};
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [PW-1:0] p;
        logic [PW-1:0] p_basic;
        logic [15:0]   w;

        repeat (3) @(posedge pclk);
        #1;
        check("rst_byte", {24'd0, pkt_if.pkt_byte}, 32'd0);
        check("rst_valid", {31'd0, pkt_if.pkt_valid}, 32'd0);
        check("rst_sop", {31'd0, pkt_if.pkt_sop}, 32'd0);
        check("rst_eop", {31'd0, pkt_if.pkt_eop}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_wc_err", {31'd0, wc_err}, 32'd0);
        rst = 1'b0;
        @(posedge pclk);
        #1;

        p_basic = rnd_payload();
        send(16'd24, p_basic, 1'b1);
        wait_idle("basic");
        check("basic_len", got_q.size(), 32'd30);
        check("basic_di", {24'd0, got_q[0]}, 32'h3E);
        check("basic_wcl", {24'd0, got_q[1]}, 32'h18);
        check("basic_wch", {24'd0, got_q[2]}, 32'h00);
        check("basic_ecc", {24'd0, got_q[3]}, 32'h0D);
        check("basic_overflow", {31'd0, overflow}, 32'd0);

        p = '0;
        for (int k = 0; k < 9; k++) p[k*8 +: 8] = 8'h31 + 8'(k);
        send(16'd9, p, 1'b1);
        wait_idle("kat");
        check("kat_len", got_q.size(), 32'd15);
`ifdef DSI_PKT_CRC_EN
        check("kat_crc_lo", {24'd0, got_q[13]}, 32'h91);
        check("kat_crc_hi", {24'd0, got_q[14]}, 32'h6F);
`else
        check("kat_crc_lo", {24'd0, got_q[13]}, 32'h00);
        check("kat_crc_hi", {24'd0, got_q[14]}, 32'h00);
`endif

        send(16'd0, rnd_payload(), 1'b1);
        wait_idle("zero");
        check("zero_len", got_q.size(), 32'd6);
`ifdef DSI_PKT_CRC_EN
        check("zero_crc", {16'd0, got_q[5], got_q[4]}, 32'hFFFF);
`else
        check("zero_crc", {16'd0, got_q[5], got_q[4]}, 32'h0000);
`endif

        rand_ready = 1'b1;
        send(16'd24, p_basic, 1'b1);
        wait_idle("bp");
        check("bp_len", got_q.size(), 32'd30);
        repeat (20) begin
            w = 16'($urandom_range(0, MAXB));
            send(w, rnd_payload(), 1'b1);
            wait_idle("rand");
        end
        rand_ready = 1'b0;

        send(16'd16, rnd_payload(), 1'b1);
        repeat (5) @(posedge pclk);
        #1;
        send(16'd10, rnd_payload(), 1'b0);
        wait_idle("ovf");
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_len", got_q.size(), 32'd22);
        check("ovf_wc_err", {31'd0, wc_err}, 32'd0);

        send(16'd40, rnd_payload(), 1'b1);
        wait_idle("wcerr");
        check("wcerr_flag", {31'd0, wc_err}, 32'd1);
        check("wcerr_wcl", {24'd0, got_q[1]}, 32'h18);
        check("wcerr_len", got_q.size(), 32'd30);

        send(16'd24, rnd_payload(), 1'b1);
        repeat (9) @(posedge pclk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", {31'd0, pkt_if.pkt_valid}, 32'd0);
        check("abort_byte", {24'd0, pkt_if.pkt_byte}, 32'd0);
        check("abort_eop", {31'd0, pkt_if.pkt_eop}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        check("abort_wc_err", {31'd0, wc_err}, 32'd0);
        exp_q = {};
        @(posedge pclk);
        #1;
        rst = 1'b0;
        @(posedge pclk);
        #1;
        send(16'd24, rnd_payload(), 1'b1);
        wait_idle("after_rst");
        check("after_rst_len", got_q.size(), 32'd30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
